// File: rtl/alu_mult_seq_pkg.sv
// Shared ALU definitions: sequential multiplier state encoding and default operand width.
package alu_mult_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/alu_negate.sv
// Conditional two's-complement negation: result = neg ? -value : value.
module alu_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    // The most-negative input maps to itself, which is the correct unsigned magnitude.
    assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/alu_mult_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, signed via sign-magnitude.
module alu_mult_seq
    import alu_mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] z,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mult_state_e        state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   x_mag;
    logic [WIDTH-1:0]   y_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] z_fixed;
    logic [WIDTH:0]     sum;
    logic               sign;
    logic               capture;
    logic               last;

    assign capture = (state == ST_IDLE) && start;
    assign last    = (cnt == CNT_W'(WIDTH - 1));

    alu_negate #(.WIDTH(WIDTH)) u_neg_x (
        .value  (x),
        .neg    (is_signed & x[WIDTH-1]),
        .result (x_mag)
    );

    alu_negate #(.WIDTH(WIDTH)) u_neg_y (
        .value  (y),
        .neg    (is_signed & y[WIDTH-1]),
        .result (y_mag)
    );

    // acc = {partial product high half, remaining multiplier bits}; carry of the add shifts in.
    assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_next = {sum, acc[WIDTH-1:1]};

    alu_negate #(.WIDTH(2*WIDTH)) u_neg_z (
        .value  (acc_next),
        .neg    (sign),
        .result (z_fixed)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand <= '0;
            acc   <= '0;
            sign  <= 1'b0;
        end else if (capture) begin
            mcand <= x_mag;
            acc   <= {{WIDTH{1'b0}}, y_mag};
            sign  <= is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
        end else if (state == ST_RUN) begin
            acc <= acc_next;
        end
    end

    // z only moves on the RUN->DONE edge, so it is stable for the ALU result mux otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z <= '0;
        end else if (state == ST_RUN && last) begin
            z <= z_fixed;
        end
    end

endmodule
